// File: rtl/hex_display_scanner_if.sv
// Display-value and scan-output bundle shared by the scanner and whatever drives it.
interface hex_display_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_en;
    logic [3:0]              hex_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    dp_out;
    logic                    frame_start;

    modport master (
        output value, dp_in, lz_en,
        input  hex_out, digit_en, dp_out, frame_start
    );

    modport slave (
        input  value, dp_in, lz_en,
        output hex_out, digit_en, dp_out, frame_start
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment digit scanner with per-frame shadowing, per-slot
// blanking and optional leading-zero suppression.
module hex_display_scanner #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned DIVIDE           = 50000,
    parameter int unsigned BLANK_CYCLES     = 500,
    parameter int unsigned ANODE_ACTIVE_LOW = 1
) (
    input logic                  clock,
    input logic                  reset,
    hex_display_scanner_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DIVIDE);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lz;
    logic                    frame_start_q;

    logic                    load;
    logic                    past_blank;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_lz;
    logic                    cur_dp;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   act;

    // Shadow load coincides with the start of digit 0's slot, i.e. frame start.
    assign load = (cnt == '0) && (idx == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            idx           <= '0;
            sh_val        <= '0;
            sh_dp         <= '0;
            sh_lz         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= load;
            if (load) begin
                sh_val <= bus.value;
                sh_dp  <= bus.dp_in;
                sh_lz  <= bus.lz_en;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (cnt >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    // A digit is LZ-blanked when it and every more-significant nibble are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (sh_val[4*i +: 4] == 4'h0);
            lz_blank[i] = sh_lz && zero_above;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_lz  = 1'b0;
        cur_dp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = sh_val[4*i +: 4];
                cur_lz  = lz_blank[i];
                cur_dp  = sh_dp[i];
            end
        end
        lit = past_blank && !cur_lz;
        act = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            act[i] = lit && (idx == IDX_W'(i));
        end
    end

    assign bus.hex_out     = cur_nib;
    assign bus.digit_en    = (ANODE_ACTIVE_LOW != 0) ? ~act : act;
    assign bus.dp_out      = lit && cur_dp;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, DIVIDE=8, BLANK_CYCLES=2.
module tb_hex_display_scanner;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   p     = 0;

    hex_display_scanner_if #(.NUM_DIGITS(4)) bus ();

    hex_display_scanner #(
        .NUM_DIGITS(4), .DIVIDE(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [3:0] en_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    task automatic step();
        @(posedge clock);
        #1;
        p++;
    endtask

    // Advance to a given slot/count within the frame (bench-tracked position).
    task automatic go_to(input int slot, input int c);
        int target;
        target = slot * 8 + c;
        for (int k = 0; k < 64 && (p % 32) != target; k++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        p = 0;
    endtask

    task automatic test_reset();
        bus.value = 16'h1234; bus.dp_in = 4'hF; bus.lz_en = 1'b0;
        do_reset();
        total++; if (bus.digit_en !== 4'hF) begin bad++; $display("FAIL reset_en got %h want f", bus.digit_en); end
        total++; if (bus.hex_out !== 4'h0) begin bad++; $display("FAIL reset_hex got %h want 0", bus.hex_out); end
        total++; if (bus.dp_out !== 1'b0) begin bad++; $display("FAIL reset_dp got %b want 0", bus.dp_out); end
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
    endtask

    task automatic test_basic_scan();
        logic [3:0] hex_tab [4];
        hex_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
        bus.value = 16'h1234; bus.dp_in = 4'h0; bus.lz_en = 1'b0;
        do_reset();
        step();
        total++; if (bus.frame_start !== 1'b1) begin bad++; $display("FAIL fs_first got %b want 1", bus.frame_start); end
        step();
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL fs_drop got %b want 0", bus.frame_start); end
        for (int s = 0; s < 4; s++) begin
            go_to(s, 1);
            total++; if (bus.digit_en !== 4'hF) begin bad++; $display("FAIL scan_blank s%0d got %h want f", s, bus.digit_en); end
            go_to(s, 2);
            total++; if (bus.digit_en !== en_tab[s]) begin bad++; $display("FAIL scan_en s%0d got %h want %h", s, bus.digit_en, en_tab[s]); end
            total++; if (bus.hex_out !== hex_tab[s]) begin bad++; $display("FAIL scan_hex s%0d got %h want %h", s, bus.hex_out, hex_tab[s]); end
            go_to(s, 7);
            total++; if (bus.digit_en !== en_tab[s]) begin bad++; $display("FAIL scan_end s%0d got %h want %h", s, bus.digit_en, en_tab[s]); end
        end
        go_to(0, 0);
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL fs_pre got %b want 0", bus.frame_start); end
        step();
        total++; if (bus.frame_start !== 1'b1) begin bad++; $display("FAIL fs_period got %b want 1", bus.frame_start); end
        step();
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL fs_post got %b want 0", bus.frame_start); end
    endtask

    task automatic test_frame_coherent();
        logic [3:0] old_tab [4];
        logic [3:0] new_tab [4];
        old_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
        new_tab = '{4'hD, 4'hC, 4'hB, 4'hA};
        go_to(1, 3);
        bus.value = 16'hABCD;
        for (int s = 1; s < 4; s++) begin
            go_to(s, 4);
            total++; if (bus.hex_out !== old_tab[s]) begin bad++; $display("FAIL coh_old s%0d got %h want %h", s, bus.hex_out, old_tab[s]); end
        end
        for (int s = 0; s < 4; s++) begin
            go_to(s, 4);
            total++; if (bus.hex_out !== new_tab[s]) begin bad++; $display("FAIL coh_new s%0d got %h want %h", s, bus.hex_out, new_tab[s]); end
            total++; if (bus.digit_en !== en_tab[s]) begin bad++; $display("FAIL coh_en s%0d got %h want %h", s, bus.digit_en, en_tab[s]); end
        end
    endtask

    task automatic test_lz_blank();
        logic [3:0] lz_en_tab [4];
        logic [3:0] lz_hex_tab [4];
        logic [3:0] zero_tab [4];
        lz_en_tab  = '{4'hE, 4'hD, 4'hF, 4'hF};
        lz_hex_tab = '{4'h0, 4'h5, 4'h0, 4'h0};
        zero_tab   = '{4'hE, 4'hF, 4'hF, 4'hF};
        bus.value = 16'h0050; bus.dp_in = 4'h0; bus.lz_en = 1'b1;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            go_to(s, 4);
            total++; if (bus.digit_en !== lz_en_tab[s]) begin bad++; $display("FAIL lz_en s%0d got %h want %h", s, bus.digit_en, lz_en_tab[s]); end
            total++; if (bus.hex_out !== lz_hex_tab[s]) begin bad++; $display("FAIL lz_hex s%0d got %h want %h", s, bus.hex_out, lz_hex_tab[s]); end
        end
        bus.value = 16'h0000;
        for (int s = 0; s < 4; s++) begin
            go_to(s, 4);
            total++; if (bus.digit_en !== zero_tab[s]) begin bad++; $display("FAIL lz_zero s%0d got %h want %h", s, bus.digit_en, zero_tab[s]); end
        end
        bus.lz_en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            go_to(s, 4);
            total++; if (bus.digit_en !== en_tab[s]) begin bad++; $display("FAIL lz_off s%0d got %h want %h", s, bus.digit_en, en_tab[s]); end
        end
    endtask

    task automatic test_decimal_point();
        logic dp_tab [4];
        dp_tab = '{1'b0, 1'b0, 1'b1, 1'b0};
        bus.value = 16'h1234; bus.dp_in = 4'b0100; bus.lz_en = 1'b0;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            go_to(s, 1);
            total++; if (bus.dp_out !== 1'b0) begin bad++; $display("FAIL dp_blank s%0d got %b want 0", s, bus.dp_out); end
            go_to(s, 2);
            total++; if (bus.dp_out !== dp_tab[s]) begin bad++; $display("FAIL dp_lit s%0d got %b want %b", s, bus.dp_out, dp_tab[s]); end
            go_to(s, 7);
            total++; if (bus.dp_out !== dp_tab[s]) begin bad++; $display("FAIL dp_end s%0d got %b want %b", s, bus.dp_out, dp_tab[s]); end
        end
        bus.value = 16'h0000; bus.lz_en = 1'b1;
        go_to(2, 4);
        total++; if (bus.dp_out !== 1'b0) begin bad++; $display("FAIL dp_lz got %b want 0", bus.dp_out); end
        total++; if (bus.digit_en !== 4'hF) begin bad++; $display("FAIL dp_lz_en got %h want f", bus.digit_en); end
    endtask

    task automatic test_reset_mid();
        bus.value = 16'h1234; bus.dp_in = 4'h0; bus.lz_en = 1'b0;
        go_to(2, 5);
        total++; if (bus.digit_en !== 4'hF) begin bad++; $display("FAIL mid_pre got %h want f", bus.digit_en); end
        do_reset();
        total++; if (bus.digit_en !== 4'hF) begin bad++; $display("FAIL mid_en got %h want f", bus.digit_en); end
        total++; if (bus.hex_out !== 4'h0) begin bad++; $display("FAIL mid_hex got %h want 0", bus.hex_out); end
        total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL mid_fs got %b want 0", bus.frame_start); end
        step();
        total++; if (bus.frame_start !== 1'b1) begin bad++; $display("FAIL mid_fs_pulse got %b want 1", bus.frame_start); end
        go_to(0, 2);
        total++; if (bus.digit_en !== 4'hE) begin bad++; $display("FAIL mid_en0 got %h want e", bus.digit_en); end
        total++; if (bus.hex_out !== 4'h4) begin bad++; $display("FAIL mid_hex0 got %h want 4", bus.hex_out); end
    endtask

    task automatic test_isolation();
        logic [15:0] vecs [4];
        vecs = '{16'hFFFF, 16'h0000, 16'h5A5A, 16'hF00F};
        bus.value = 16'h1234; bus.dp_in = 4'b0010; bus.lz_en = 1'b0;
        do_reset();
        go_to(1, 0);
        for (int k = 0; k < 2; k++) begin
            bus.value = vecs[k];
            total++; if (bus.digit_en !== 4'hF) begin bad++; $display("FAIL iso_en c%0d got %h want f", k, bus.digit_en); end
            total++; if (bus.dp_out !== 1'b0) begin bad++; $display("FAIL iso_dp c%0d got %b want 0", k, bus.dp_out); end
            total++; if (bus.hex_out !== 4'h3) begin bad++; $display("FAIL iso_hex c%0d got %h want 3", k, bus.hex_out); end
            step();
        end
        for (int k = 2; k < 4; k++) begin
            bus.value = vecs[k];
            step();
            total++; if (bus.digit_en !== 4'hD) begin bad++; $display("FAIL iso_lit_en c%0d got %h want d", k, bus.digit_en); end
            total++; if (bus.dp_out !== 1'b1) begin bad++; $display("FAIL iso_lit_dp c%0d got %b want 1", k, bus.dp_out); end
            total++; if (bus.hex_out !== 4'h3) begin bad++; $display("FAIL iso_lit_hex c%0d got %h want 3", k, bus.hex_out); end
        end
    endtask

    initial begin
        bus.value = '0;
        bus.dp_in = '0;
        bus.lz_en = 1'b0;
        test_reset();
        test_basic_scan();
        test_frame_coherent();
        test_lz_blank();
        test_decimal_point();
        test_reset_mid();
        test_isolation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
